// File: rtl/mdio_slave_mp.sv
// MDIO management slave answering a block of consecutive PHY addresses.
// MDC and MDIO are oversampled in the clk_i domain; each register access is a one-cycle strobe.
module mdio_slave_mp #(
  parameter int PHY_BASE     = 0,
  parameter int NUM_PHY      = 1,
  parameter int PRE_LEN      = 32,
  parameter int PRE_SUPPRESS = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic        read_en,
  output logic [4:0]  read_phy,
  output logic [4:0]  read_addr,
  input  logic [15:0] read_data,
  output logic        write_en,
  output logic [4:0]  write_phy,
  output logic [4:0]  write_addr,
  output logic [15:0] write_data,
  output logic        frame_err
);

  typedef enum logic [2:0] {PRE, HDR, TA_RD, RD_DATA, TA_WR, WR_DATA, WR_COMMIT, SKIP} state_e;

  localparam logic [5:0] PRE_LEN_C = 6'(PRE_LEN);
  localparam logic [5:0] PRE_END_C = (PRE_SUPPRESS != 0) ? 6'(PRE_LEN) : 6'd0;
  localparam logic [5:0] PHY_LO_C  = 6'(PHY_BASE);
  localparam logic [5:0] PHY_HI_C  = 6'(PHY_BASE + NUM_PHY);
  localparam logic [4:0] PHY_OFS_C = 5'(PHY_BASE);

  logic [1:0]  mdc_sync_q, mdio_sync_q;
  logic        mdc_prev_q;
  logic        mdc_edge, bit_in;

  state_e      state_q, state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [12:0] hdr_q, hdr_d;
  logic        ta_first_q, ta_first_d;
  logic [15:0] rd_shift_q, rd_shift_d;
  logic [15:0] wr_shift_q, wr_shift_d;
  logic        rd_cap_q;
  logic [4:0]  pend_phy_q, pend_phy_d, pend_addr_q, pend_addr_d;

  logic        mdio_o_q, mdio_o_d, mdio_oe_q, mdio_oe_d;
  logic        read_en_q, read_en_d, write_en_q, write_en_d, frame_err_q, frame_err_d;
  logic [4:0]  read_phy_q, read_phy_d, read_addr_q, read_addr_d;
  logic [4:0]  write_phy_q, write_phy_d, write_addr_q, write_addr_d;
  logic [15:0] write_data_q, write_data_d;

  logic [13:0] hdr_full;
  logic [1:0]  st, op;
  logic [4:0]  phyad, regad;
  logic        phy_hit;

  // MDIO passes through the same two-flop depth as MDC, so the sampled bit lines up with the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mdc_sync_q  <= '0;
      mdio_sync_q <= '0;
      mdc_prev_q  <= 1'b0;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[0], mdc_i};
      mdio_sync_q <= {mdio_sync_q[0], mdio_i};
      mdc_prev_q  <= mdc_sync_q[1];
    end
  end

  assign mdc_edge = mdc_sync_q[1] & ~mdc_prev_q;
  assign bit_in   = mdio_sync_q[1];

  assign hdr_full = {hdr_q, bit_in};
  assign st       = hdr_full[13:12];
  assign op       = hdr_full[11:10];
  assign phyad    = hdr_full[9:5];
  assign regad    = hdr_full[4:0];
  assign phy_hit  = ({1'b0, phyad} >= PHY_LO_C) && ({1'b0, phyad} < PHY_HI_C);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    hdr_d        = hdr_q;
    ta_first_d   = ta_first_q;
    rd_shift_d   = rd_cap_q ? read_data : rd_shift_q;
    wr_shift_d   = wr_shift_q;
    pend_phy_d   = pend_phy_q;
    pend_addr_d  = pend_addr_q;
    mdio_o_d     = mdio_o_q;
    mdio_oe_d    = mdio_oe_q;
    read_en_d    = 1'b0;
    read_phy_d   = read_phy_q;
    read_addr_d  = read_addr_q;
    write_en_d   = 1'b0;
    write_phy_d  = write_phy_q;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    frame_err_d  = 1'b0;

    case (state_q)
      PRE: if (mdc_edge) begin
        if (bit_in) begin
          pre_cnt_d = (pre_cnt_q == 6'd63) ? 6'd63 : pre_cnt_q + 6'd1;
        end else if (pre_cnt_q >= PRE_LEN_C) begin
          state_d   = HDR;
          hdr_d     = '0;
          bit_cnt_d = '0;
        end else begin
          pre_cnt_d = '0;
        end
      end
      HDR: if (mdc_edge) begin
        hdr_d     = {hdr_q[11:0], bit_in};
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd12) begin
          bit_cnt_d = '0;
          if (st != 2'b01 || op == 2'b00 || op == 2'b11) begin
            frame_err_d = 1'b1;
            pre_cnt_d   = '0;
            state_d     = PRE;
          end else if (!phy_hit) begin
            state_d = SKIP;
          end else if (op == 2'b10) begin
            read_en_d   = 1'b1;
            read_phy_d  = phyad - PHY_OFS_C;
            read_addr_d = regad;
            state_d     = TA_RD;
          end else begin
            pend_phy_d  = phyad - PHY_OFS_C;
            pend_addr_d = regad;
            state_d     = TA_WR;
          end
        end
      end
      TA_RD: if (mdc_edge) begin
        if (bit_cnt_q == 5'd0) begin
          bit_cnt_d = 5'd1;
        end else begin
          mdio_oe_d = 1'b1;
          mdio_o_d  = 1'b0;
          bit_cnt_d = '0;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: if (mdc_edge) begin
        if (bit_cnt_q == 5'd16) begin
          mdio_oe_d = 1'b0;
          mdio_o_d  = 1'b1;
          pre_cnt_d = PRE_END_C;
          state_d   = PRE;
        end else begin
          mdio_o_d   = rd_shift_q[15];
          rd_shift_d = {rd_shift_q[14:0], 1'b0};
          bit_cnt_d  = bit_cnt_q + 5'd1;
        end
      end
      TA_WR: if (mdc_edge) begin
        if (bit_cnt_q == 5'd0) begin
          ta_first_d = bit_in;
          bit_cnt_d  = 5'd1;
        end else if (ta_first_q && !bit_in) begin
          bit_cnt_d = '0;
          state_d   = WR_DATA;
        end else begin
          // Bad turnaround: discard the 16 data bits like an unserved frame.
          frame_err_d = 1'b1;
          bit_cnt_d   = 5'd2;
          state_d     = SKIP;
        end
      end
      WR_DATA: if (mdc_edge) begin
        wr_shift_d = {wr_shift_q[14:0], bit_in};
        bit_cnt_d  = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd15) state_d = WR_COMMIT;
      end
      WR_COMMIT: begin
        write_en_d   = 1'b1;
        write_phy_d  = pend_phy_q;
        write_addr_d = pend_addr_q;
        write_data_d = wr_shift_q;
        pre_cnt_d    = PRE_END_C;
        state_d      = PRE;
      end
      SKIP: if (mdc_edge) begin
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd17) begin
          pre_cnt_d = PRE_END_C;
          state_d   = PRE;
        end
      end
      default: state_d = PRE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same old values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= PRE;
      pre_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      hdr_q        <= '0;
      ta_first_q   <= 1'b0;
      rd_shift_q   <= '0;
      wr_shift_q   <= '0;
      rd_cap_q     <= 1'b0;
      pend_phy_q   <= '0;
      pend_addr_q  <= '0;
      mdio_o_q     <= 1'b1;
      mdio_oe_q    <= 1'b0;
      read_en_q    <= 1'b0;
      read_phy_q   <= '0;
      read_addr_q  <= '0;
      write_en_q   <= 1'b0;
      write_phy_q  <= '0;
      write_addr_q <= '0;
      write_data_q <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      hdr_q        <= hdr_d;
      ta_first_q   <= ta_first_d;
      rd_shift_q   <= rd_shift_d;
      wr_shift_q   <= wr_shift_d;
      rd_cap_q     <= read_en_q;
      pend_phy_q   <= pend_phy_d;
      pend_addr_q  <= pend_addr_d;
      mdio_o_q     <= mdio_o_d;
      mdio_oe_q    <= mdio_oe_d;
      read_en_q    <= read_en_d;
      read_phy_q   <= read_phy_d;
      read_addr_q  <= read_addr_d;
      write_en_q   <= write_en_d;
      write_phy_q  <= write_phy_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign mdio_o     = mdio_o_q;
  assign mdio_oe    = mdio_oe_q;
  assign read_en    = read_en_q;
  assign read_phy   = read_phy_q;
  assign read_addr  = read_addr_q;
  assign write_en   = write_en_q;
  assign write_phy  = write_phy_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_mdio_slave_mp.sv
// Directed bench for mdio_slave_mp: three instances share one MDC/MDIO stimulus stream
// (normal, preamble-suppressing, and zero-length-preamble configurations).
module tb_mdio_slave_mp;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mdc_i = 1'b0;
  logic        mdio_i = 1'b1;
  logic [15:0] read_data = 16'h796D;

  logic        mdio_o_a, mdio_oe_a, read_en_a, write_en_a, frame_err_a;
  logic [4:0]  read_phy_a, read_addr_a, write_phy_a, write_addr_a;
  logic [15:0] write_data_a;
  logic        mdio_o_s, mdio_oe_s, read_en_s, write_en_s, frame_err_s;
  logic [4:0]  read_phy_s, read_addr_s, write_phy_s, write_addr_s;
  logic [15:0] write_data_s;
  logic        mdio_o_z, mdio_oe_z, read_en_z, write_en_z, frame_err_z;
  logic [4:0]  read_phy_z, read_addr_z, write_phy_z, write_addr_z;
  logic [15:0] write_data_z;

  mdio_slave_mp #(.PHY_BASE(4), .NUM_PHY(2), .PRE_LEN(32), .PRE_SUPPRESS(0)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .mdc_i(mdc_i), .mdio_i(mdio_i),
    .mdio_o(mdio_o_a), .mdio_oe(mdio_oe_a),
    .read_en(read_en_a), .read_phy(read_phy_a), .read_addr(read_addr_a), .read_data(read_data),
    .write_en(write_en_a), .write_phy(write_phy_a), .write_addr(write_addr_a),
    .write_data(write_data_a), .frame_err(frame_err_a));

  mdio_slave_mp #(.PHY_BASE(4), .NUM_PHY(2), .PRE_LEN(32), .PRE_SUPPRESS(1)) dut_s (
    .clk_i(clk_i), .rst_i(rst_i), .mdc_i(mdc_i), .mdio_i(mdio_i),
    .mdio_o(mdio_o_s), .mdio_oe(mdio_oe_s),
    .read_en(read_en_s), .read_phy(read_phy_s), .read_addr(read_addr_s), .read_data(read_data),
    .write_en(write_en_s), .write_phy(write_phy_s), .write_addr(write_addr_s),
    .write_data(write_data_s), .frame_err(frame_err_s));

  mdio_slave_mp #(.PHY_BASE(0), .NUM_PHY(32), .PRE_LEN(0), .PRE_SUPPRESS(0)) dut_z (
    .clk_i(clk_i), .rst_i(rst_i), .mdc_i(mdc_i), .mdio_i(mdio_i),
    .mdio_o(mdio_o_z), .mdio_oe(mdio_oe_z),
    .read_en(read_en_z), .read_phy(read_phy_z), .read_addr(read_addr_z), .read_data(read_data),
    .write_en(write_en_z), .write_phy(write_phy_z), .write_addr(write_addr_z),
    .write_data(write_data_z), .frame_err(frame_err_z));

  always #5 clk_i = ~clk_i;

  // Strobe and drive activity counted per clk_i cycle.
  int wcnt_a = 0, rcnt_a = 0, ecnt_a = 0, oecyc_a = 0, both_a = 0;
  int wcnt_s = 0, both_s = 0, wcnt_z = 0;
  always @(posedge clk_i) begin
    if (write_en_a) wcnt_a++;
    if (read_en_a) rcnt_a++;
    if (frame_err_a) ecnt_a++;
    if (mdio_oe_a) oecyc_a++;
    if (read_en_a && write_en_a) both_a++;
    if (write_en_s) wcnt_s++;
    if (read_en_s && write_en_s) both_s++;
    if (write_en_z) wcnt_z++;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Per-bit log of dut_a's drive, sampled at the end of each MDC high phase.
  int          bit_idx = 0;
  logic [39:0] oe_log = '0;
  logic [39:0] o_log = '0;

  task automatic send_bit(input logic b);
    mdio_i = b;
    mdc_i  = 1'b0;
    repeat (8) @(negedge clk_i);
    mdc_i = 1'b1;
    repeat (8) @(negedge clk_i);
    if (bit_idx < 40) begin
      oe_log[bit_idx] = mdio_oe_a;
      o_log[bit_idx]  = mdio_o_a;
    end
    bit_idx++;
  endtask

  task automatic send_frame(input int pre_n, input logic [1:0] st, input logic [1:0] op,
                            input logic [4:0] phy, input logic [4:0] regad,
                            input logic [1:0] ta, input logic [15:0] data);
    logic [31:0] f;
    f = {st, op, phy, regad, ta, data};
    for (int i = 0; i < pre_n; i++) send_bit(1'b1);
    bit_idx = 0;
    oe_log  = '0;
    o_log   = '0;
    for (int i = 31; i >= 0; i--) send_bit(f[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] rd_val;
    logic [39:0] oe_exp, o_exp;
    int w0, r0, e0, oc0, ws0, wz0;

    rd_val = 16'h796D;
    oe_exp = 40'h00_FFFF_8000;
    o_exp  = '0;
    for (int i = 0; i <= 14; i++) o_exp[i] = 1'b1;
    for (int k = 0; k < 16; k++) o_exp[16+k] = rd_val[15-k];
    o_exp[32] = 1'b1;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_mdio_oe", 40'(mdio_oe_a), 40'd0);
    check("rst_mdio_o", 40'(mdio_o_a), 40'd1);
    check("rst_strobes", 40'({read_en_a, write_en_a, frame_err_a}), 40'd0);
    check("rst_wr_outs", 40'({write_phy_a, write_addr_a, write_data_a}), 40'd0);
    check("rst_rd_outs", 40'({read_phy_a, read_addr_a}), 40'd0);
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);

    // Write with no preamble straight after reset: only the PRE_LEN=0 instance accepts it
    w0 = wcnt_a; ws0 = wcnt_s; wz0 = wcnt_z;
    send_frame(0, 2'b01, 2'b01, 5'd4, 5'd2, 2'b10, 16'h1234);
    repeat (4) @(negedge clk_i);
    check("pre0_wr_cnt", 40'(wcnt_z - wz0), 40'd1);
    check("pre0_wr_vals", 40'({write_phy_z, write_addr_z, write_data_z}), 40'({5'd4, 5'd2, 16'h1234}));
    check("nopre_wr_a", 40'(wcnt_a - w0), 40'd0);
    check("nopre_wr_s", 40'(wcnt_s - ws0), 40'd0);

    // Write PHY5 reg 9 data A55A after full preamble
    w0 = wcnt_a; r0 = rcnt_a; e0 = ecnt_a; ws0 = wcnt_s;
    send_frame(32, 2'b01, 2'b01, 5'd5, 5'd9, 2'b10, 16'hA55A);
    repeat (4) @(negedge clk_i);
    check("wr_cnt", 40'(wcnt_a - w0), 40'd1);
    check("wr_vals", 40'({write_phy_a, write_addr_a, write_data_a}), 40'({5'd1, 5'd9, 16'hA55A}));
    check("wr_no_rd_err", 40'({rcnt_a - r0, ecnt_a - e0}), 40'd0);
    check("wr_cnt_s", 40'(wcnt_s - ws0), 40'd1);

    // Read PHY4 reg 1
    r0 = rcnt_a; oc0 = oecyc_a; e0 = ecnt_a;
    send_frame(32, 2'b01, 2'b10, 5'd4, 5'd1, 2'b11, 16'hFFFF);
    send_bit(1'b1);
    check("rd_cnt", 40'(rcnt_a - r0), 40'd1);
    check("rd_phy_addr", 40'({read_phy_a, read_addr_a}), 40'({5'd0, 5'd1}));
    check("rd_oe_bits", oe_log, oe_exp);
    check("rd_o_bits", o_log, o_exp);
    check("rd_oe_cycles", 40'(oecyc_a - oc0), 40'd272);
    check("rd_no_err", 40'(ecnt_a - e0), 40'd0);

    // Read unserved PHY7, then a normal read to PHY4
    r0 = rcnt_a; oc0 = oecyc_a;
    send_frame(32, 2'b01, 2'b10, 5'd7, 5'd1, 2'b11, 16'hFFFF);
    send_bit(1'b1);
    check("skip_rd_cnt", 40'(rcnt_a - r0), 40'd0);
    check("skip_oe_cycles", 40'(oecyc_a - oc0), 40'd0);
    r0 = rcnt_a;
    send_frame(32, 2'b01, 2'b10, 5'd4, 5'd1, 2'b11, 16'hFFFF);
    send_bit(1'b1);
    check("after_skip_rd_cnt", 40'(rcnt_a - r0), 40'd1);
    check("after_skip_oe_bits", oe_log, oe_exp);
    check("after_skip_o_bits", o_log, o_exp);

    // ST=00, then write with bad turnaround
    w0 = wcnt_a; r0 = rcnt_a; e0 = ecnt_a;
    send_frame(32, 2'b00, 2'b01, 5'd4, 5'd0, 2'b10, 16'hFFFF);
    repeat (4) @(negedge clk_i);
    check("st00_err", 40'(ecnt_a - e0), 40'd1);
    check("st00_no_strobe", 40'({wcnt_a - w0, rcnt_a - r0}), 40'd0);
    e0 = ecnt_a;
    send_frame(32, 2'b01, 2'b01, 5'd4, 5'd3, 2'b11, 16'h0F0F);
    repeat (4) @(negedge clk_i);
    check("ta11_err", 40'(ecnt_a - e0), 40'd1);
    check("ta11_no_write", 40'(wcnt_a - w0), 40'd0);

    // Two writes back to back, the second without preamble
    w0 = wcnt_a; ws0 = wcnt_s;
    send_frame(32, 2'b01, 2'b01, 5'd4, 5'd5, 2'b10, 16'h1357);
    send_frame(0, 2'b01, 2'b01, 5'd5, 5'd6, 2'b10, 16'h2468);
    repeat (4) @(negedge clk_i);
    check("b2b_cnt_sup", 40'(wcnt_s - ws0), 40'd2);
    check("b2b_vals_sup", 40'({write_phy_s, write_addr_s, write_data_s}), 40'({5'd1, 5'd6, 16'h2468}));
    check("b2b_cnt_nosup", 40'(wcnt_a - w0), 40'd1);
    check("b2b_vals_nosup", 40'({write_phy_a, write_addr_a, write_data_a}), 40'({5'd0, 5'd5, 16'h1357}));

    // Reset during the 8th read data bit
    begin
      logic [31:0] f;
      f = {2'b01, 2'b10, 5'd4, 5'd1, 18'h3FFFF};
      for (int i = 0; i < 32; i++) send_bit(1'b1);
      for (int i = 31; i >= 9; i--) send_bit(f[i]);
    end
    mdio_i = 1'b1;
    mdc_i  = 1'b0;
    repeat (8) @(negedge clk_i);
    mdc_i = 1'b1;
    repeat (4) @(negedge clk_i);
    check("mid_rd_oe", 40'(mdio_oe_a), 40'd1);
    check("mid_rd_bit8", 40'(mdio_o_a), 40'(rd_val[8]));
    rst_i = 1'b1;
    #1;
    check("rst_async_oe", 40'(mdio_oe_a), 40'd0);
    check("rst_async_o", 40'(mdio_o_a), 40'd1);
    check("rst_async_outs", 40'({read_en_a, read_addr_a, write_data_a}), 40'd0);
    mdc_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    w0 = wcnt_a; ws0 = wcnt_s;
    send_frame(0, 2'b01, 2'b01, 5'd4, 5'd7, 2'b10, 16'hBEEF);
    repeat (4) @(negedge clk_i);
    check("post_rst_nopre_a", 40'(wcnt_a - w0), 40'd0);
    check("post_rst_nopre_s", 40'(wcnt_s - ws0), 40'd0);
    check("strobe_overlap", 40'(both_a + both_s), 40'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/mdio_slave_mp.md
MDIO_SLAVE_MP -- requirements
Module: mdio_slave_mp

Interface
REQ-001 SHALL have parameter PHY_BASE, default 0: lowest PHY address served (0..31).
REQ-002 SHALL have parameter NUM_PHY, default 1: number of consecutive PHY addresses served (1..32, PHY_BASE+NUM_PHY<=32).
REQ-003 SHALL have parameter PRE_LEN, default 32: consecutive preamble 1s required before a start bit (0..32).
REQ-004 SHALL have parameter PRE_SUPPRESS, default 0: 1 = back-to-back frames accepted without preamble.
REQ-005 SHALL have ports: clk_i in 1, system clock; rst_i in 1, reset, asynchronous, active-high.
REQ-006 SHALL have ports: mdc_i in 1, MDC (async); mdio_i in 1, MDIO input (async); mdio_o out 1, MDIO drive value; mdio_oe out 1, MDIO drive enable.
REQ-007 SHALL have ports: read_en out 1, read strobe; read_phy out 5, index (addr-PHY_BASE); read_addr out 5, register; read_data in 16, register value.
REQ-008 SHALL have ports: write_en out 1, write strobe; write_phy out 5; write_addr out 5; write_data out 16.
REQ-009 SHALL have port: frame_err out 1, one-cycle pulse per malformed frame.

Function
REQ-010 mdc_i, mdio_i SHALL pass 2-flop synchronisers; MDC edge = synchronised rising edge; mdio sampled from synchroniser output on that edge.
REQ-011 All bit-level actions SHALL occur only in the clk_i cycle of a detected MDC edge unless stated.
REQ-012 States: PRE, HDR, TA_RD, RD_DATA, TA_WR, WR_DATA, WR_COMMIT, SKIP.
REQ-013 PRE: saturating 6-bit ones-counter; 1 increments, 0 with count<PRE_LEN clears count, 0 with count>=PRE_LEN = ST bit 1, go HDR.
REQ-014 HDR: shift 13 further bits (ST2, OP[2], PHYAD[5], REGAD[5]); decision on edge of 14th header bit.
REQ-015 ST!=01 or OP in {00,11}: frame_err pulse, count cleared, go PRE.
REQ-016 PHYAD outside [PHY_BASE, PHY_BASE+NUM_PHY-1]: go SKIP; 18 edges, no drive, no strobe; then frame end.
REQ-017 Read (OP=10) matched: read_en=1 next clk_i cycle for exactly 1 cycle with read_phy/read_addr valid; read_data captured 1 clk_i cycle after read_en; go TA_RD.
REQ-018 TA_RD: 1st TA edge mdio_oe stays 0; 2nd TA edge mdio_oe=1, mdio_o=0; go RD_DATA.
REQ-019 RD_DATA: 16 edges, each drives next captured bit MSB first; 17th edge mdio_oe=0, mdio_o=1, frame end.
REQ-020 Write (OP=01) matched: go TA_WR; TA bits shall be 1,0, else frame_err pulse after TA, remaining 16 bits ignored (SKIP-like), no write.
REQ-021 WR_DATA: shift 16 bits; after 16th edge go WR_COMMIT.
REQ-022 WR_COMMIT: write_en=1 for exactly 1 clk_i cycle, write_phy/addr/data stable that cycle and held until next write; go frame end.
REQ-023 Frame end: go PRE with count=PRE_LEN if PRE_SUPPRESS=1, else count=0.
REQ-024 PRE_LEN=0: first 0 after reset is a start bit.
REQ-025 mdio_oe SHALL be 1 only during 2nd TA bit and 16 read data bits of a matched read.
REQ-026 read_en and write_en SHALL never assert together; at most one strobe per frame.
REQ-027 mdio_o, mdio_oe, strobes, frame_err SHALL be registered outputs.

Reset
REQ-028 rst_i SHALL immediately force: mdio_oe=0, mdio_o=1, read_en=0, write_en=0, frame_err=0, all address/data outputs 0, state PRE, count 0, synchronisers 0.
REQ-029 Reset mid-read SHALL release MDIO at once; after release a full PRE_LEN preamble is required regardless of PRE_SUPPRESS.

Verification
REQ-030 PHY_BASE=4,NUM_PHY=2: 32x1, write PHY5 reg 0x09 data 0xA55A -> one write_en, write_phy=1, write_addr=9, write_data=0xA55A.
REQ-031 Read PHY4 reg 0x01, read_data=0x796D -> read_en once, read_phy=0; mdio_oe on 2nd TA bit; bits 0,0111100101101101 driven; oe=0 after.
REQ-032 Read PHY 7 (unserved) -> no strobe, mdio_oe=0 all frame; next 32-preamble frame to PHY4 serviced normally.
REQ-033 ST=00 after preamble -> one frame_err, no strobe; write with TA=11 -> one frame_err, no write_en.
REQ-034 PRE_SUPPRESS=1, PRE_LEN=32: two writes back-to-back without preamble -> two write_en; PRE_SUPPRESS=0 same stimulus -> one write_en.
REQ-035 rst_i asserted at 8th read data bit -> mdio_oe=0 same cycle; frame without preamble after reset ignored.
